// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared opcode encodings, FSM states and latencies for the MDU.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // Fixed by the 1-bit-per-cycle divider; must not be overridden.
    localparam int DIV_LAT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// ============================================================================
// Module : mdu_if
// Brief  : EX-stage request/response bundle between the hazard/EX logic and
//          the MDU. The flush signal exists only when MDU_FLUSH_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MDU_FLUSH_EN
    logic        flush;
`endif

    modport master (
        output A, B, op, start,
`ifdef MDU_FLUSH_EN
        output flush,
`endif
        input  busy, HI, LO
    );

    modport slave (
        input  A, B, op, start,
`ifdef MDU_FLUSH_EN
        input  flush,
`endif
        output busy, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/mdu_divider.sv
// ============================================================================
// Module : mdu_divider
// Brief  : Unsigned 32-bit restoring divider, one quotient bit per cycle.
//          The load edge performs the first step, so done rises 32 cycles later.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mdu_divider (
    input  wire         clk,
    input  wire         reset,
    input  wire         load,
    input  wire  [31:0] dividend,
    input  wire  [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    localparam logic [5:0] c_steps = 6'd32;

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic        r_done;

    logic [31:0] w_rem_in;
    logic [31:0] w_quo_in;
    logic [31:0] w_dvs_in;
    logic [32:0] w_shift;
    logic [31:0] w_sub;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;

    always_comb begin
        w_rem_in = load ? 32'd0    : r_rem;
        w_quo_in = load ? dividend : r_quo;
        w_dvs_in = load ? divisor  : r_dvs;
        w_shift  = {w_rem_in, w_quo_in[31]};
        w_ge     = (w_shift >= {1'b0, w_dvs_in});
        // Difference always fits in 32 bits whenever it is taken.
        w_sub    = w_shift[31:0] - w_dvs_in;
        w_rem_nx = w_ge ? w_sub : w_shift[31:0];
        w_quo_nx = {w_quo_in[30:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (load) begin
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
            r_dvs  <= divisor;
            r_cnt  <= 6'd1;
            r_done <= 1'b0;
        end else if (r_cnt != 6'd0 && r_cnt != c_steps) begin
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
            r_cnt  <= r_cnt + 6'd1;
            r_done <= (r_cnt == c_steps - 6'd1);
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// ============================================================================
// Module : mdu
// Brief  : Multi-cycle multiply/divide unit owning the architectural HI/LO.
//          Optional MDU_FLUSH_EN adds a flush input that aborts in-flight ops.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5
) (
    input  wire   clk,
    input  wire   reset,
    mdu_if.slave  bus
);

    mdu_state_e  r_state;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_prod;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_div_signed;

    logic        w_flush;
    logic        w_accept;
    logic        w_div_load;
    logic        w_mul_signed;
    logic        w_div_signed;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic        w_div_done;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

`ifdef MDU_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_accept     = bus.start && !w_flush && (r_state == ST_IDLE);
    assign w_div_load   = w_accept && is_div_op(bus.op);
    assign w_mul_signed = (bus.op == MDU_MULT);
    assign w_div_signed = (bus.op == MDU_DIV);

    // Low 64 bits of a product of 64-bit extensions equal the true product.
    assign w_a64  = {{32{w_mul_signed & bus.A[31]}}, bus.A};
    assign w_b64  = {{32{w_mul_signed & bus.B[31]}}, bus.B};
    assign w_prod = w_a64 * w_b64;

    assign w_dvd = (w_div_signed && bus.A[31]) ? -bus.A : bus.A;
    assign w_dvs = (w_div_signed && bus.B[31]) ? -bus.B : bus.B;

    mdu_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .load      (w_div_load),
        .dividend  (w_dvd),
        .divisor   (w_dvs),
        .quotient  (w_q_mag),
        .remainder (w_r_mag),
        .done      (w_div_done)
    );

    // Sign restoration plus the divide-by-zero and overflow overrides.
    always_comb begin
        w_res_lo = (r_div_signed && (r_a[31] ^ r_b[31])) ? -w_q_mag : w_q_mag;
        w_res_hi = (r_div_signed && r_a[31]) ? -w_r_mag : w_r_mag;
        if (r_b == 32'd0) begin
            w_res_lo = 32'hFFFF_FFFF;
            w_res_hi = r_a;
        end else if (r_div_signed && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
            w_res_lo = 32'h8000_0000;
            w_res_hi = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_prod       <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_div_signed <= 1'b0;
        end else if (w_flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            MDU_MULT, MDU_MULTU: begin
                                r_state <= ST_MUL;
                                r_cnt   <= 6'(MULT_LAT);
                                r_busy  <= 1'b1;
                                r_prod  <= w_prod;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                r_state      <= ST_DIV;
                                r_cnt        <= 6'(DIV_LAT);
                                r_busy       <= 1'b1;
                                r_a          <= bus.A;
                                r_b          <= bus.B;
                                r_div_signed <= w_div_signed;
                            end
                            MDU_MTHI: r_hi <= bus.A;
                            MDU_MTLO: r_lo <= bus.A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (r_cnt == 6'd1) begin
                        {r_hi, r_lo} <= r_prod;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the single-cycle ALU and takes the same forwarded A/B operands.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and raises busy so the hazard unit stalls MFHI/MFLO and any later MDU op.
- Results are consumed by the MFHI/MFLO path into the MEM/WB result mux.

Parameters:
- MULT_LAT, 5, cycles from accepted MULT/MULTU to HI/LO update (legal 1..16).
- DIV_LAT, 32, cycles from accepted DIV/DIVU to HI/LO update; fixed by the 1-bit-per-cycle divider, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- A  in  32  operand rs, signed view for signed ops.
- B  in  32  operand rt.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved, no effect.
- start  in  1  single-cycle request; op, A and B are sampled on the same edge.
- busy  out  1  operation in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, FSM=IDLE.
- Reset wins over every other input, including mid-operation; a partial result is discarded.
- FSM states: IDLE, MUL, DIV.
  - IDLE + start + op 0/1 -> MUL with counter=MULT_LAT.
  - IDLE + start + op 2/3 -> DIV with counter=DIV_LAT.
  - Any other state/input combination stays in the current state.
- busy = (state != IDLE), registered.
- Timing for a start accepted at edge t:
  - busy is 1 from cycle t+1 through t+LAT.
  - HI/LO and busy=0 appear together at cycle t+LAT+1.
- MTHI/MTLO:
  - Accepted only in IDLE.
  - HI<=A (op 4) or LO<=A (op 5) at the sampling edge.
  - busy never asserts.
- start while busy:
  - Ignored; no queueing. The hazard unit must not issue this.
  - The bench checks that the in-flight result is unaffected.
- Operands are latched at acceptance; A/B/op changes during busy have no effect.
- MULT: {HI,LO} = signed 64-bit product of A and B.
- MULTU: {HI,LO} = unsigned 64-bit product of A and B.
- The product is computed at acceptance and delayed MULT_LAT cycles; a pipelined or iterative implementation is acceptable if it meets the exact latency.
- DIVU: LO=quotient, HI=remainder, unsigned.
- DIV:
  - Operate on magnitudes, then negate the quotient if the signs differ.
  - The remainder takes the sign of the dividend (truncating division).
- Division by zero, both signed and unsigned: LO=32'hFFFF_FFFF, HI=A. Still takes DIV_LAT cycles.
- DIV overflow (A=32'h8000_0000, B=32'hFFFF_FFFF): LO=32'h8000_0000, HI=0.
- HI/LO are held between operations; no partial results are ever visible.
- Reserved op with start: no state change, busy stays 0.

Optional Feature:
- Macro MDU_FLUSH_EN. When defined, adds input port flush (1 bit).
- Behaviour with the macro: flush=1 in any cycle returns the FSM to IDLE at that edge.
  - busy=0 at the next cycle; HI/LO are left unchanged.
  - flush and start in the same cycle: flush wins and start is dropped, including MTHI/MTLO.
  - flush while IDLE has no effect.
- Without the macro: the port is absent; in-flight operations always complete (precise-exception handling stalls until !busy).

Decomposition:
- Package mdu_pkg holds:
  - op encodings MDU_MULT..MDU_MTLO;
  - state encodings;
  - DIV_LAT=32.
- One sub-module: mdu_divider.
  - Unsigned 32-bit restoring divider, one quotient bit per cycle.
  - Ports: load, dividend, divisor, quotient, remainder, done.
- Sign pre/post-processing and the divide-by-zero/overflow overrides stay in mdu.

Test Plan:
- MULT A=-3 (FFFF_FFFD), B=7, start at t -> busy 1 for 5 cycles; at t+6 HI=FFFF_FFFF, LO=FFFF_FFEB, busy=0.
- MULTU A=FFFF_FFFF, B=FFFF_FFFF -> HI=FFFF_FFFE, LO=0000_0001 after 5 cycles.
- DIV A=-7, B=2 -> after 32 busy cycles LO=FFFF_FFFD, HI=FFFF_FFFF. DIVU A=7, B=0 -> LO=FFFF_FFFF, HI=7. DIV 8000_0000/FFFF_FFFF -> LO=8000_0000, HI=0.
- MTHI A=1234_5678 -> HI=1234_5678 next cycle, busy never 1. MTLO issued while a DIV is busy -> ignored, LO = divide result.
- reset asserted at busy cycle 10 of DIV -> next cycle busy=0, HI=LO=0; a new MULT 2*3 then gives LO=6, HI=0.
- MDU_FLUSH_EN: MULT after MTLO 55, flush in busy cycle 2 -> busy=0 next cycle, LO=55 retained; flush+start same cycle -> no operation starts.
